shift_sequencer: RTL and testbench

- Multi-cycle variable-amount shift controller for the execute stage.
- Uses the team's fixed shift-by-2 step as its datapath primitive. A final single-bit step covers odd amounts.
- Implements SLL/SRL, and optionally SRA, by amounts 0..31, with a Start/Busy/Done handshake to the pipeline control.
- Exists so the datapath does not need a full combinational barrel shifter.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 103 ++++++++++
 tb/tb_shift_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Start/Busy/Done handshake bundle between pipeline control and shift_sequencer.
// The Arith request bit exists only when SHIFT_SEQ_ARITH_EN is defined.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic             i_start;
    logic [WIDTH-1:0] i_shift_in;
    logic [AMT_W-1:0] i_sh_amt;
    logic             i_dir;
`ifdef SHIFT_SEQ_ARITH_EN
    logic             i_arith;
`endif
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_shift_out;

`ifdef SHIFT_SEQ_ARITH_EN
    modport master (output i_start, i_shift_in, i_sh_amt, i_dir, i_arith,
                    input  o_busy, o_done, o_shift_out);
    modport slave  (input  i_start, i_shift_in, i_sh_amt, i_dir, i_arith,
                    output o_busy, o_done, o_shift_out);
`else
    modport master (output i_start, i_shift_in, i_sh_amt, i_dir,
                    input  o_busy, o_done, o_shift_out);
    modport slave  (input  i_start, i_shift_in, i_sh_amt, i_dir,
                    output o_busy, o_done, o_shift_out);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL shifter built from a shift-by-2 step plus a final 1-bit step.
// Define SHIFT_SEQ_ARITH_EN to add the Arith request bit (sign-filling right shifts).
module shift_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    shift_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [AMT_W-1:0]   r_rem;
    logic [AMT_W-1:0]   w_rem_nxt;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_shift_out;
    logic               w_fill;

`ifdef SHIFT_SEQ_ARITH_EN
    logic               r_arith;
    assign w_fill = r_dir & r_arith & r_acc[WIDTH-1];
`else
    assign w_fill = 1'b0;
`endif

    // State, operand and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_shift_out <= '0;
`ifdef SHIFT_SEQ_ARITH_EN
            r_arith     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_rem   <= w_rem_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
            if (r_state == IDLE && bus.i_start) begin
                r_dir   <= bus.i_dir;
`ifdef SHIFT_SEQ_ARITH_EN
                r_arith <= bus.i_arith;
`endif
            end
            // Result is latched on entry to DONE so it is valid alongside the pulse
            if (w_state_nxt == DONE) begin
                r_shift_out <= w_acc_nxt;
            end
        end
    end

    // Next-state and datapath step
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_acc_nxt   = bus.i_shift_in;
                    w_rem_nxt   = bus.i_sh_amt;
                    w_state_nxt = (bus.i_sh_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_rem >= AMT_W'(2)) begin
                    w_acc_nxt = r_dir ? {{2{w_fill}}, r_acc[WIDTH-1:2]}
                                      : {r_acc[WIDTH-3:0], 2'b00};
                    w_rem_nxt = r_rem - AMT_W'(2);
                end else if (r_rem == AMT_W'(1)) begin
                    w_acc_nxt = r_dir ? {w_fill, r_acc[WIDTH-1:1]}
                                      : {r_acc[WIDTH-2:0], 1'b0};
                    w_rem_nxt = '0;
                end
                if (r_rem <= AMT_W'(2)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_shift_out = r_shift_out;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (covers SHIFT_SEQ_ARITH_EN when defined).
module tb_shift_sequencer;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AMT_W = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) sif ();

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] din, input logic [4:0] amt,
                         input logic dir, input logic arith);
        sif.i_shift_in = din;
        sif.i_sh_amt   = amt;
        sif.i_dir      = dir;
`ifdef SHIFT_SEQ_ARITH_EN
        sif.i_arith    = arith;
`else
        if (arith) $display("note: arith request ignored in this build");
`endif
    endtask

    // Launch one request, then check latency, busy, result and single-pulse Done
    task automatic run_op(input string tag, input logic [31:0] din, input logic [4:0] amt,
                          input logic dir, input logic arith,
                          input logic [31:0] exp_out, input int exp_lat);
        int cyc;
        int busy_bad;
        drive(din, amt, dir, arith);
        sif.i_start = 1'b1;
        #1;
        check({tag, "_busy_accept"}, 32'(sif.o_busy), 32'd0);
        tick();
        sif.i_start = 1'b0;
        drive(32'hA5A5_5A5A, 5'd7, ~dir, 1'b0);
        cyc = 1;
        busy_bad = 0;
        while (!sif.o_done && cyc < 40) begin
            if (sif.o_busy !== 1'b1) busy_bad++;
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, "_result"}, sif.o_shift_out, exp_out);
        tick();
        check({tag, "_done_once"}, {30'd0, sif.o_done, sif.o_busy}, 32'd0);
        check({tag, "_hold"}, sif.o_shift_out, exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic [31:0] captured;

        reset = 1'b1;
        sif.i_start = 1'b0;
        drive(32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", 32'(sif.o_busy), 32'd0);
            check("idle_done", 32'(sif.o_done), 32'd0);
            check("idle_out", sif.o_shift_out, 32'd0);
        end

        run_op("sll4",  32'h0000_0001, 5'd4,  1'b0, 1'b0, 32'h0000_0010, 3);
        run_op("srl31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 17);
        run_op("amt0",  32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 1);
        run_op("sll5",  32'h0000_0003, 5'd5,  1'b0, 1'b0, 32'h0000_0060, 4);
        run_op("srl2",  32'h0000_0008, 5'd2,  1'b1, 1'b0, 32'h0000_0002, 2);
        run_op("srl3l", 32'hF000_0000, 5'd3,  1'b1, 1'b0, 32'h1E00_0000, 3);
        run_op("sll31", 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 17);

        // Start while busy must be ignored
        drive(32'h0000_00FF, 5'd8, 1'b0, 1'b0);
        sif.i_start = 1'b1;
        tick();
        sif.i_start = 1'b0;
        tick();
        drive(32'h1234_5678, 5'd1, 1'b1, 1'b0);
        sif.i_start = 1'b1;
        tick();
        sif.i_start = 1'b0;
        dones = 0;
        captured = 32'h0;
        for (int i = 0; i < 20; i++) begin
            if (sif.o_done) begin
                dones++;
                captured = sif.o_shift_out;
            end
            tick();
        end
        check("busy_ignore_dones", 32'(dones), 32'd1);
        check("busy_ignore_result", captured, 32'h0000_FF00);

        // Reset in the 4th SHIFT cycle aborts without a Done pulse
        drive(32'h0000_0001, 5'd20, 1'b0, 1'b0);
        sif.i_start = 1'b1;
        tick();
        sif.i_start = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_busy_before", 32'(sif.o_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(sif.o_busy), 32'd0);
        check("midrst_out", sif.o_shift_out, 32'd0);
        dones = (sif.o_done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sif.o_done === 1'b1) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_op("post_rst", 32'h0000_0001, 5'd1, 1'b0, 1'b0, 32'h0000_0002, 2);

`ifdef SHIFT_SEQ_ARITH_EN
        run_op("sra3",  32'hF000_0000, 5'd3,  1'b1, 1'b1, 32'hFE00_0000, 3);
        run_op("srl3a", 32'hF000_0000, 5'd3,  1'b1, 1'b0, 32'h1E00_0000, 3);
        run_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 17);
        run_op("sla4",  32'h8000_0001, 5'd4,  1'b0, 1'b1, 32'h0000_0010, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
